// File: rtl/ser_status_irq.sv
// ser_status_irq: POKEY IRQST/SKSTAT latching, IRQEN masking, SKRES service and irq_n.
// SER_OVERRUN_EN enables serial-input overrun detection on SKSTAT[6].
module ser_status_irq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enn,
  input  logic [7:0] Dw,
  input  logic       AddrEw,
  input  logic       AddrAw,
  input  logic       setSdiCompl,
  input  logic       setFramerr,
  input  logic       setSdoCompl,
  input  logic       sdoFinish,
  input  logic       sdiBusy,
  input  logic       siDelay,
  input  logic       Timer1,
  input  logic       Timer2,
  input  logic       Timer4,
  input  logic       setKeyIrq,
  input  logic       setBrkIrq,
  input  logic       setKbOvr,
  input  logic       keyDown,
  input  logic       shiftDown,
  output logic [7:0] IRQST,
  output logic [7:0] SKSTAT,
  output logic       irq_n
);

  logic [7:0] irqen;
  logic [7:0] irqst_l;
  logic [7:0] en_eff;
  logic [7:0] ev;
  logic       frm_err_n;
  logic       sdi_ovr_n;
  logic       kb_ovr_n;

  assign en_eff = AddrEw ? Dw : irqen;
  // Bit 3 follows the sdoFinish level, so its latch slot never captures an event.
  assign ev = {setBrkIrq, setKeyIrq, setSdiCompl, setSdoCompl, 1'b0, Timer4, Timer2, Timer1};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      irqen     <= 8'h00;
      irqst_l   <= 8'hFF;
      frm_err_n <= 1'b1;
      kb_ovr_n  <= 1'b1;
    end else if (enn) begin
      irqen     <= en_eff;
      irqst_l   <= (irqst_l & ~(ev & en_eff)) | ~en_eff | 8'h08;
      // Set events outrank SKRES so an error arriving with the reset is kept.
      if (setFramerr)
        frm_err_n <= 1'b0;
      else if (AddrAw)
        frm_err_n <= 1'b1;
      if (setKbOvr)
        kb_ovr_n <= 1'b0;
      else if (AddrAw)
        kb_ovr_n <= 1'b1;
    end
  end

`ifdef SER_OVERRUN_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sdi_ovr_n <= 1'b1;
    end else if (enn) begin
      if (setSdiCompl && !irqst_l[5])
        sdi_ovr_n <= 1'b0;
      else if (AddrAw)
        sdi_ovr_n <= 1'b1;
    end
  end
`else
  assign sdi_ovr_n = 1'b1;
`endif

  assign IRQST  = {irqst_l[7:4], irqst_l[3] & ~(sdoFinish & irqen[3]), irqst_l[2:0]};
  assign SKSTAT = {frm_err_n, sdi_ovr_n, kb_ovr_n, siDelay, ~shiftDown, ~keyDown, ~sdiBusy, 1'b1};
  assign irq_n  = &IRQST;

endmodule

// File: tb/tb_ser_status_irq.sv
// Bench for ser_status_irq: directed vectors, per-cycle model compare, literal spot checks.
module tb_ser_status_irq;

  logic       clk = 1'b0;
  logic       rst_n, enn, AddrEw, AddrAw;
  logic [7:0] Dw;
  logic       setSdiCompl, setFramerr, setSdoCompl, sdoFinish, sdiBusy, siDelay;
  logic       Timer1, Timer2, Timer4, setKeyIrq, setBrkIrq, setKbOvr, keyDown, shiftDown;
  logic [7:0] IRQST, SKSTAT;
  logic       irq_n;

  int  checks = 0;
  int  errors = 0;
  bit  chk_on = 1'b0;

  // Model state: pending flags and error flags are active-high here.
  logic [7:0] m_irqen;
  bit         m_pend[8];
  bit         m_frm, m_ovr, m_kb;

  always #5 clk = ~clk;

  ser_status_irq dut (
    .clk(clk), .rst_n(rst_n), .enn(enn), .Dw(Dw), .AddrEw(AddrEw), .AddrAw(AddrAw),
    .setSdiCompl(setSdiCompl), .setFramerr(setFramerr), .setSdoCompl(setSdoCompl),
    .sdoFinish(sdoFinish), .sdiBusy(sdiBusy), .siDelay(siDelay),
    .Timer1(Timer1), .Timer2(Timer2), .Timer4(Timer4),
    .setKeyIrq(setKeyIrq), .setBrkIrq(setBrkIrq), .setKbOvr(setKbOvr),
    .keyDown(keyDown), .shiftDown(shiftDown),
    .IRQST(IRQST), .SKSTAT(SKSTAT), .irq_n(irq_n)
  );

  task automatic model_step();
    logic [7:0] ne;
    bit ev[8];
    bit was5;
    if (!rst_n) begin
      m_irqen = 8'h00;
      for (int k = 0; k < 8; k++) m_pend[k] = 1'b0;
      m_frm = 1'b0; m_ovr = 1'b0; m_kb = 1'b0;
      return;
    end
    if (!enn) return;
    ne = AddrEw ? Dw : m_irqen;
    ev[0] = Timer1; ev[1] = Timer2; ev[2] = Timer4; ev[3] = 1'b0;
    ev[4] = setSdoCompl; ev[5] = setSdiCompl; ev[6] = setKeyIrq; ev[7] = setBrkIrq;
    was5 = m_pend[5];
    for (int k = 0; k < 8; k++) begin
      if (!ne[k]) m_pend[k] = 1'b0;
      else if (ev[k]) m_pend[k] = 1'b1;
    end
    if (AddrAw) begin m_frm = 1'b0; m_ovr = 1'b0; m_kb = 1'b0; end
    if (setFramerr) m_frm = 1'b1;
    if (setKbOvr) m_kb = 1'b1;
`ifdef SER_OVERRUN_EN
    if (setSdiCompl && was5) m_ovr = 1'b1;
`endif
    m_irqen = ne;
  endtask

  function automatic logic [7:0] exp_irqst();
    logic [7:0] r;
    for (int k = 0; k < 8; k++) r[k] = !m_pend[k];
    r[3] = !(sdoFinish && m_irqen[3]);
    return r;
  endfunction

  function automatic logic [7:0] exp_skstat();
    return {!m_frm, !m_ovr, !m_kb, siDelay, !shiftDown, !keyDown, !sdiBusy, 1'b1};
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_irqst", IRQST, exp_irqst());
      chk("model_skstat", SKSTAT, exp_skstat());
      chk("model_irq_n", {7'd0, irq_n}, {7'd0, &exp_irqst()});
    end
  end

  task automatic clr();
    AddrEw = 0; AddrAw = 0; Dw = 8'h00;
    setSdiCompl = 0; setFramerr = 0; setSdoCompl = 0;
    Timer1 = 0; Timer2 = 0; Timer4 = 0;
    setKeyIrq = 0; setBrkIrq = 0; setKbOvr = 0;
  endtask

  task automatic tick(input bit e);
    enn = e;
    @(posedge clk);
    model_step();
    #1;
  endtask

  // One enn-qualified edge carrying the staged pulses, then one idle edge.
  task automatic en_cycle();
    tick(1'b1);
    clr();
    tick(1'b0);
  endtask

  task automatic wr_irqen(input logic [7:0] v);
    AddrEw = 1; Dw = v;
    en_cycle();
  endtask

  initial begin
    rst_n = 0; enn = 0; clr();
    sdoFinish = 0; sdiBusy = 0; siDelay = 1; keyDown = 0; shiftDown = 0;
    tick(1'b0);
    chk_on = 1'b1;
    tick(1'b0);
    rst_n = 1;
    tick(1'b0);
    chk("rst_irqst", IRQST, 8'hFF);
    chk("rst_irq_n", {7'd0, irq_n}, 8'h01);
    chk("rst_skstat", SKSTAT, 8'hFF);

    // Receive path
    wr_irqen(8'h20);
    setSdiCompl = 1; en_cycle();
    chk("rx_irqst", IRQST, 8'hDF);
    chk("rx_irq_n", {7'd0, irq_n}, 8'h00);
    setSdiCompl = 1; en_cycle();
`ifdef SER_OVERRUN_EN
    chk("ovr_sk6", {7'd0, SKSTAT[6]}, 8'h00);
`else
    chk("ovr_sk6_off", {7'd0, SKSTAT[6]}, 8'h01);
`endif
    AddrAw = 1; en_cycle();
    chk("skres_sk6", {7'd0, SKSTAT[6]}, 8'h01);
    chk("skres_irq5", {7'd0, IRQST[5]}, 8'h00);
    wr_irqen(8'h00);
    chk("dis_irqst", IRQST, 8'hFF);
    chk("dis_irq_n", {7'd0, irq_n}, 8'h01);
    // Receive with bit 5 masked never overruns
    setSdiCompl = 1; en_cycle();
    setSdiCompl = 1; en_cycle();
    chk("mask_no_ovr", SKSTAT, 8'hFF);

    // Frame error
    setFramerr = 1; en_cycle();
    chk("frm_sk7", {7'd0, SKSTAT[7]}, 8'h00);
    chk("frm_irq_n", {7'd0, irq_n}, 8'h01);
    AddrAw = 1; setFramerr = 1; en_cycle();
    chk("frm_skres_race", {7'd0, SKSTAT[7]}, 8'h00);
    AddrAw = 1; en_cycle();
    chk("frm_cleared", SKSTAT, 8'hFF);

    // Transmit
    wr_irqen(8'h18);
    setSdoCompl = 1; en_cycle();
    chk("tx_irq4", IRQST, 8'hEF);
    sdoFinish = 1; #1;
    chk("tx_fin", IRQST, 8'hE7);
    tick(1'b0);
    sdoFinish = 0; #1;
    chk("tx_fin_drop", IRQST, 8'hEF);
    tick(1'b0);

    // Simultaneous enable write and event; masked Timer2
    AddrEw = 1; Dw = 8'h01; Timer1 = 1; en_cycle();
    chk("sim_en_ev", IRQST, 8'hFE);
    Timer2 = 1; en_cycle();
    chk("t2_masked", IRQST, 8'hFE);

    // Keyboard, break, timers; pulses held while enn=0 must be ignored
    wr_irqen(8'hC7);
    Timer4 = 1; tick(1'b0); tick(1'b0); clr();
    chk("enn_gate", IRQST, 8'hFE);
    Timer4 = 1; setKeyIrq = 1; en_cycle();
    chk("t4_key", IRQST, 8'hBA);
    setBrkIrq = 1; Timer2 = 1; setKbOvr = 1; en_cycle();
    chk("brk_t2", IRQST, 8'h38);
    chk("kbovr", SKSTAT, 8'hDF);
    keyDown = 1; shiftDown = 1; sdiBusy = 1; siDelay = 0; tick(1'b0);
    chk("levels", SKSTAT, 8'hC1);
    wr_irqen(8'h06);
    chk("partial_dis", IRQST, 8'hF9);
    AddrAw = 1; en_cycle();
    keyDown = 0; shiftDown = 0; sdiBusy = 0; siDelay = 1;

    // Reset with a coincident pulse
    setFramerr = 1; setKeyIrq = 1; rst_n = 0; tick(1'b1);
    clr(); rst_n = 1; tick(1'b0);
    chk("rst_mid_irqst", IRQST, 8'hFF);
    chk("rst_mid_skstat", SKSTAT, 8'hFF);
    tick(1'b0);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
